// File: rtl/enc_capture_mc_pkg.sv
// enc_capture_mc_pkg: shared edge-mode encodings and sizing helpers for the encoder capture block
package enc_capture_mc_pkg;
  typedef enum logic [1:0] {
    EM_RISE = 2'b00,
    EM_FALL = 2'b01,
    EM_BOTH = 2'b10,
    EM_NONE = 2'b11
  } edge_mode_e;
  localparam int SETTLE_CYC = 3;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/enc_chan_filt.sv
// enc_chan_filt: per-channel synchroniser, glitch filter and registered qualified edge pulse
module enc_chan_filt
  import enc_capture_mc_pkg::*;
#(
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_in,
  input  logic [1:0]        edge_mode,
  input  logic [FILT_W-1:0] filt_len,
  output logic              edge_p
);
  logic s1, s2, lvl, lvl_d, settled, rise, fall, hit;
  logic [FILT_W-1:0] run;
  logic [1:0] settle;
  // qualify the level change against the selected edge mode
  always_comb begin
    settled = settle == 2'(SETTLE_CYC);
    rise = lvl & ~lvl_d;
    fall = ~lvl & lvl_d;
    hit = (edge_mode == EM_RISE) ? rise :
          (edge_mode == EM_FALL) ? fall :
          (edge_mode == EM_BOTH) ? (rise | fall) : 1'b0;
  end
  // sync, filter and edge register; after reset the level is seeded from the synchroniser with edges inhibited
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      lvl_d <= 1'b0;
      run <= '0;
      settle <= '0;
      edge_p <= 1'b0;
    end else begin
      s1 <= enc_in;
      s2 <= s1;
      edge_p <= settled & hit;
      if (!settled) begin
        settle <= settle + 2'd1;
        lvl <= s2;
        lvl_d <= s2;
        run <= '0;
      end else begin
        lvl_d <= lvl;
        if (s2 == lvl) run <= '0;
        else if (run >= filt_len) begin
          lvl <= s2;
          run <= '0;
        end else run <= run + FILT_W'(1);
      end
    end
  end
endmodule

// File: rtl/enc_capture_mc.sv
// enc_capture_mc: multi-channel encoder edge capture with timestamps, round-robin arbiter and stream output
module enc_capture_mc
  import enc_capture_mc_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int TS_W   = 32,
  parameter int CNT_W  = 32,
  parameter int FILT_W = 4,
  localparam int CW    = ch_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   enc_in,
  input  logic              en,
  input  logic [1:0]        edge_mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              ts_clr,
  input  logic              ovf_clr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW-1:0]     m_ch,
  output logic [TS_W-1:0]   m_ts,
  output logic [CNT_W-1:0]  m_cnt,
  output logic [N_CH-1:0]   ovf
);
  logic [N_CH-1:0] edge_p, pend, fly, cand, free, take, drop;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] slot_cnt [N_CH];
  logic [TS_W-1:0] slot_ts [N_CH];
  logic [TS_W-1:0] ts;
  logic [CW-1:0] ptr, gnt;
  logic xfer, found, load;
  int idx;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    enc_chan_filt #(.FILT_W(FILT_W)) u_filt (
      .clk(clk),
      .rst(rst),
      .enc_in(enc_in[g]),
      .edge_mode(edge_mode),
      .filt_len(filt_len),
      .edge_p(edge_p[g])
    );
  end

  // slot bookkeeping: a slot stays occupied while its event sits in the output stage, freed on transfer
  always_comb begin
    xfer = m_valid & m_ready;
    free = '0;
    take = '0;
    drop = '0;
    for (int i = 0; i < N_CH; i++) begin
      free[i] = xfer && (m_ch == CW'(i));
      take[i] = en & edge_p[i] & (~pend[i] | free[i]);
      drop[i] = en & edge_p[i] & pend[i] & ~free[i];
    end
  end

  // round-robin search from ptr over pending slots not already presented
  always_comb begin
    fly = m_valid ? (N_CH'(1) << m_ch) : '0;
    cand = pend & ~fly;
    found = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      idx = (idx >= N_CH) ? idx - N_CH : idx;
      if (!found && cand[idx]) begin
        found = 1'b1;
        gnt = CW'(idx);
      end
    end
    load = found & (~m_valid | m_ready);
  end

  // free-running timestamp; clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else ts <= ts_clr ? '0 : ts + TS_W'(1);
  end

  // per-channel edge counters, one-entry slots and sticky overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      ovf <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
        slot_cnt[i] <= '0;
        slot_ts[i] <= '0;
      end
    end else begin
      pend <= take | (pend & ~free);
      ovf <= drop | (ovf & ~{N_CH{ovf_clr}});
      for (int i = 0; i < N_CH; i++) begin
        if (en && edge_p[i]) cnt[i] <= cnt[i] + CNT_W'(1);
        if (take[i]) begin
          slot_cnt[i] <= cnt[i] + CNT_W'(1);
          slot_ts[i] <= ts;
        end
      end
    end
  end

  // registered output stage and arbiter pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_ch <= '0;
      m_ts <= '0;
      m_cnt <= '0;
      ptr <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_ch <= gnt;
      m_ts <= slot_ts[gnt];
      m_cnt <= slot_cnt[gnt];
      ptr <= (gnt == CW'(N_CH - 1)) ? '0 : gnt + CW'(1);
    end else if (xfer) m_valid <= 1'b0;
  end
endmodule

// File: tb/tb_enc_capture_mc.sv
// tb_enc_capture_mc: directed scenario tests for the encoder capture block
module tb_enc_capture_mc;
  import enc_capture_mc_pkg::*;
  localparam int N_CH = 4, TS_W = 8, CNT_W = 16, FILT_W = 4;
  logic clk = 1'b0;
  logic rst, en, ts_clr, ovf_clr, m_ready, m_valid;
  logic [N_CH-1:0] enc_in, ovf;
  logic [1:0] edge_mode;
  logic [FILT_W-1:0] filt_len;
  logic [1:0] m_ch;
  logic [TS_W-1:0] m_ts;
  logic [CNT_W-1:0] m_cnt;
  int total = 0, bad = 0, cyc = 0;
  int q_ch[$], q_cnt[$], q_ts[$], q_cyc[$];

  enc_capture_mc #(.N_CH(N_CH), .TS_W(TS_W), .CNT_W(CNT_W), .FILT_W(FILT_W)) dut (
    .clk(clk), .rst(rst), .enc_in(enc_in), .en(en), .edge_mode(edge_mode),
    .filt_len(filt_len), .ts_clr(ts_clr), .ovf_clr(ovf_clr), .m_valid(m_valid),
    .m_ready(m_ready), .m_ch(m_ch), .m_ts(m_ts), .m_cnt(m_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // log every handshake that will complete at the next rising edge
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      q_ch.push_back(int'(m_ch));
      q_cnt.push_back(int'(m_cnt));
      q_ts.push_back(int'(m_ts));
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    q_ch.delete();
    q_cnt.delete();
    q_ts.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; enc_in = '0; en = 1'b1; edge_mode = EM_RISE; filt_len = '0;
    ts_clr = 1'b0; ovf_clr = 1'b0; m_ready = 1'b1;
    tick(3);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", m_valid); end
    total++; if (m_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", m_ch); end
    total++; if (m_ts !== 8'd0) begin bad++; $display("FAIL reset_ts got=%0d exp=0", m_ts); end
    total++; if (m_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", m_cnt); end
    total++; if (ovf !== 4'd0) begin bad++; $display("FAIL reset_ovf got=%b exp=0000", ovf); end
    rst = 1'b0;
    tick(8);
    total++; if (m_valid !== 1'b0 || q_ch.size() != 0) begin bad++; $display("FAIL reset_quiet got=%0b/%0d exp=0/0", m_valid, q_ch.size()); end
  endtask

  task automatic test_single_pulse;
    clear_q();
    enc_in[2] = 1'b1;
    tick(5);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL pulse_early got=%0b exp=0", m_valid); end
    tick(1);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL pulse_valid got=%0b exp=1", m_valid); end
    total++; if (m_ch !== 2'd2) begin bad++; $display("FAIL pulse_ch got=%0d exp=2", m_ch); end
    total++; if (m_cnt !== 16'd1) begin bad++; $display("FAIL pulse_cnt got=%0d exp=1", m_cnt); end
    tick(4);
    enc_in[2] = 1'b0;
    tick(12);
    total++; if (q_ch.size() != 1) begin bad++; $display("FAIL pulse_count got=%0d exp=1", q_ch.size()); end
  endtask

  task automatic test_glitch_filter;
    filt_len = 4'd3;
    clear_q();
    enc_in[0] = 1'b1; tick(3); enc_in[0] = 1'b0;
    tick(15);
    total++; if (q_ch.size() != 0) begin bad++; $display("FAIL glitch_events got=%0d exp=0", q_ch.size()); end
    enc_in[0] = 1'b1; tick(5); enc_in[0] = 1'b0;
    tick(15);
    total++;
    if (q_ch.size() != 1) begin bad++; $display("FAIL filt_events got=%0d exp=1", q_ch.size()); end
    else if (q_ch[0] != 0 || q_cnt[0] != 1) begin bad++; $display("FAIL filt_event got=ch%0d/cnt%0d exp=ch0/cnt1", q_ch[0], q_cnt[0]); end
    filt_len = '0;
  endtask

  task automatic test_overflow;
    clear_q();
    m_ready = 1'b0;
    enc_in[1] = 1'b1; tick(3); enc_in[1] = 1'b0; tick(3);
    enc_in[1] = 1'b1; tick(3); enc_in[1] = 1'b0; tick(10);
    total++; if (m_valid !== 1'b1 || m_ch !== 2'd1) begin bad++; $display("FAIL ovf_held got=%0b/ch%0d exp=1/ch1", m_valid, m_ch); end
    total++; if (m_cnt !== 16'd1) begin bad++; $display("FAIL ovf_held_cnt got=%0d exp=1", m_cnt); end
    total++; if (ovf !== 4'b0010) begin bad++; $display("FAIL ovf_set got=%b exp=0010", ovf); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL ovf_clr got=%b exp=0000", ovf); end
    m_ready = 1'b1; tick(1);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%0b exp=0", m_valid); end
    clear_q();
    enc_in[1] = 1'b1; tick(10); enc_in[1] = 1'b0; tick(3);
    total++;
    if (q_cnt.size() != 1) begin bad++; $display("FAIL ovf_next_events got=%0d exp=1", q_cnt.size()); end
    else if (q_cnt[0] != 3) begin bad++; $display("FAIL ovf_next_cnt got=%0d exp=3", q_cnt[0]); end
  endtask

  task automatic test_back_to_back;
    rst = 1'b1; enc_in = '0; tick(2); rst = 1'b0; tick(5);
    for (int r = 1; r <= 2; r++) begin
      clear_q();
      enc_in = 4'hF;
      tick(12);
      total++;
      if (q_ch.size() != 4) begin bad++; $display("FAIL b2b_events r%0d got=%0d exp=4", r, q_ch.size()); end
      else for (int i = 0; i < 4; i++) begin
        total++;
        if (q_ch[i] != i || q_cnt[i] != r || q_cyc[i] - q_cyc[0] != i)
          begin bad++; $display("FAIL b2b r%0d slot%0d got=ch%0d/cnt%0d/dt%0d exp=ch%0d/cnt%0d/dt%0d", r, i, q_ch[i], q_cnt[i], q_cyc[i] - q_cyc[0], i, r, i); end
      end
      enc_in = '0;
      tick(10);
    end
  endtask

  task automatic test_en_gate;
    clear_q();
    en = 1'b0;
    enc_in[0] = 1'b1; tick(10);
    total++; if (q_ch.size() != 0) begin bad++; $display("FAIL en_gate got=%0d exp=0", q_ch.size()); end
    enc_in[0] = 1'b0; en = 1'b1; tick(10);
    enc_in[0] = 1'b1; tick(10);
    total++;
    if (q_cnt.size() != 1) begin bad++; $display("FAIL en_resume_events got=%0d exp=1", q_cnt.size()); end
    else if (q_cnt[0] != 3) begin bad++; $display("FAIL en_resume_cnt got=%0d exp=3", q_cnt[0]); end
  endtask

  task automatic test_ts_wrap;
    edge_mode = EM_BOTH;
    clear_q();
    ts_clr = 1'b1; tick(1); ts_clr = 1'b0;
    tick(250);
    enc_in[3] = 1'b1; tick(2);
    enc_in[3] = 1'b0; tick(12);
    total++;
    if (q_ts.size() != 2) begin bad++; $display("FAIL wrap_events got=%0d exp=2", q_ts.size()); end
    else begin
      total++; if (q_ts[0] != 254 || q_cnt[0] != 3) begin bad++; $display("FAIL wrap_first got=ts%0d/cnt%0d exp=ts254/cnt3", q_ts[0], q_cnt[0]); end
      total++; if (q_ts[1] != 0 || q_cnt[1] != 4) begin bad++; $display("FAIL wrap_second got=ts%0d/cnt%0d exp=ts0/cnt4", q_ts[1], q_cnt[1]); end
    end
    tick(7);
    ts_clr = 1'b1; tick(1); ts_clr = 1'b0;
    tick(5);
    clear_q();
    enc_in[3] = 1'b1; tick(12);
    total++;
    if (q_ts.size() != 1) begin bad++; $display("FAIL tsclr_events got=%0d exp=1", q_ts.size()); end
    else if (q_ts[0] != 9 || q_cnt[0] != 5) begin bad++; $display("FAIL tsclr_event got=ts%0d/cnt%0d exp=ts9/cnt5", q_ts[0], q_cnt[0]); end
  endtask

  task automatic test_reset_mid;
    edge_mode = EM_RISE;
    enc_in = '0; tick(10);
    clear_q();
    m_ready = 1'b0;
    enc_in = 4'b0011; tick(10);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%0b exp=1", m_valid); end
    rst = 1'b1; tick(1);
    total++;
    if (m_valid !== 1'b0 || m_ch !== 2'd0 || m_ts !== 8'd0 || m_cnt !== 16'd0 || ovf !== 4'd0)
      begin bad++; $display("FAIL mid_rst got=v%0b/ch%0d/ts%0d/cnt%0d/ovf%b exp=all zero", m_valid, m_ch, m_ts, m_cnt, ovf); end
    rst = 1'b0; m_ready = 1'b1;
    tick(20);
    total++; if (q_ch.size() != 0 || m_valid !== 1'b0) begin bad++; $display("FAIL mid_no_event got=%0d/%0b exp=0/0", q_ch.size(), m_valid); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_glitch_filter();
    test_overflow();
    test_back_to_back();
    test_en_gate();
    test_ts_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
